// File: rtl/sample_capture_pkg.sv
// Shared configuration for the logic-analyzer capture front end.
// Holds the default sizes and the capture FSM state encoding.
package sample_capture_pkg;

   localparam int DEF_CHANNEL_COUNT    = 10;
   localparam int DEF_SAMPLE_BUFF_SIZE = 640;
   localparam int DEF_DIV_WIDTH        = 16;
   localparam int DEF_SYNC_STAGES      = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

endpackage

// File: rtl/sample_capture_input_synchronizer.sv
// Per-bit flop chain that brings asynchronous probe inputs into the clk domain.
// Every stage clears to 0 on reset.
module input_synchronizer #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [STAGES-1:0] chain;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               chain <= '0;
            end else begin
               chain <= {chain[STAGES-2:0], d[gi]};
            end
         end

         assign q[gi] = chain[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/sample_capture.sv
// Capture front end: synchronizes and decimates the probes, waits for a trigger,
// then streams a fixed number of samples into the per-channel SIPO buffers.
module sample_capture
   import sample_capture_pkg::*;
#(
   parameter int  CHANNEL_COUNT    = DEF_CHANNEL_COUNT,
   parameter int  SAMPLE_BUFF_SIZE = DEF_SAMPLE_BUFF_SIZE,
   parameter int  DIV_WIDTH        = DEF_DIV_WIDTH,
   parameter int  SYNC_STAGES      = DEF_SYNC_STAGES,
   localparam int COUNT_WIDTH      = $clog2(SAMPLE_BUFF_SIZE + 1)
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CHANNEL_COUNT-1:0] chan_in,
   input  logic [CHANNEL_COUNT-1:0] chan_enable,
   input  logic [DIV_WIDTH-1:0]     div_value,
   input  logic [CHANNEL_COUNT-1:0] trig_mask,
   input  logic [CHANNEL_COUNT-1:0] trig_value,
   input  logic                     trig_edge,
   input  logic                     arm,
   input  logic                     abort,
   output logic                     sample_shift,
   output logic [CHANNEL_COUNT-1:0] sample_data,
   output logic                     armed,
   output logic                     capturing,
   output logic                     capture_done,
   output logic [COUNT_WIDTH-1:0]   sample_count
);

   logic [CHANNEL_COUNT-1:0] s;
   capture_state_t           state;
   capture_state_t           state_next;
   logic [DIV_WIDTH-1:0]     div_cnt;
   logic                     run;
   logic                     tick;
   logic                     cond;
   logic                     cond_prev;
   logic                     prev_valid;
   logic                     trigger;
   logic                     shift_now;
   logic [COUNT_WIDTH-1:0]   count_inc;
   logic                     last_sample;

   input_synchronizer #(
      .WIDTH  (CHANNEL_COUNT),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (chan_in),
      .q     (s)
   );

   // The >= compare keeps a lowered div_value from wrapping the counter.
   assign run  = (state == ARMED) || (state == CAPTURE);
   assign tick = run && (div_cnt >= div_value);

   // An edge needs a false sample actually observed in ARMED, so a condition
   // already true at arm time does not fire until it drops and returns.
   assign cond    = (((s ^ trig_value) & trig_mask) == '0);
   assign trigger = trig_edge ? (cond && !cond_prev && prev_valid) : cond;

   assign shift_now   = tick && (((state == ARMED) && trigger) || (state == CAPTURE));
   assign count_inc   = sample_count + 1'b1;
   assign last_sample = (count_inc == COUNT_WIDTH'(SAMPLE_BUFF_SIZE));

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (shift_now) state_next = last_sample ? DONE : CAPTURE;
            CAPTURE: if (shift_now && last_sample) state_next = DONE;
            DONE:    if (arm) state_next = ARMED;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         div_cnt      <= '0;
         cond_prev    <= 1'b0;
         prev_valid   <= 1'b0;
         sample_shift <= 1'b0;
         sample_data  <= '0;
         armed        <= 1'b0;
         capturing    <= 1'b0;
         capture_done <= 1'b0;
         sample_count <= '0;
      end else begin
         state        <= state_next;
         armed        <= (state_next == ARMED);
         capturing    <= (state_next == CAPTURE);
         capture_done <= (state_next == DONE);
         sample_shift <= shift_now && !abort;

         if (shift_now && !abort) begin
            sample_data <= s & chan_enable;
         end

         if (abort || ((state_next == ARMED) && (state != ARMED))) begin
            sample_count <= '0;
         end else if (shift_now) begin
            sample_count <= count_inc;
         end

         // Outside ARMED/CAPTURE the divider sits at 0, which also clears it on entry.
         div_cnt <= (run && !tick) ? div_cnt + 1'b1 : '0;

         if (state != ARMED) begin
            cond_prev  <= 1'b0;
            prev_valid <= 1'b0;
         end else if (tick) begin
            cond_prev  <= cond;
            prev_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: stimulus pushes expected shifts (data and
// clk cycle), a negedge monitor pops and compares every sample_shift pulse.
module tb_sample_capture;

   localparam int CH  = 10;
   localparam int N   = 640;
   localparam int DW  = 16;
   localparam int CW  = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] chan_in = '0;
   logic [CH-1:0] chan_enable = '1;
   logic [DW-1:0] div_value = '0;
   logic [CH-1:0] trig_mask = '0;
   logic [CH-1:0] trig_value = '0;
   logic          trig_edge = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          sample_shift;
   logic [CH-1:0] sample_data;
   logic          armed;
   logic          capturing;
   logic          capture_done;
   logic [CW-1:0] sample_count;

   typedef struct {
      int data;
      int at;
   } shift_exp_t;

   shift_exp_t exp_q[$];
   shift_exp_t mon_e;
   int         cyc = 0;
   int         checks = 0;
   int         passes = 0;
   logic       mon_en = 1'b0;

   sample_capture dut (
      .clk          (clk),
      .reset        (reset),
      .chan_in      (chan_in),
      .chan_enable  (chan_enable),
      .div_value    (div_value),
      .trig_mask    (trig_mask),
      .trig_value   (trig_value),
      .trig_edge    (trig_edge),
      .arm          (arm),
      .abort        (abort),
      .sample_shift (sample_shift),
      .sample_data  (sample_data),
      .armed        (armed),
      .capturing    (capturing),
      .capture_done (capture_done),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en && sample_shift) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_shift cyc=%0d data=%h expected no shift", cyc, sample_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (int'(sample_data) == mon_e.data && cyc == mon_e.at) begin
               passes++;
               $display("shift ok cyc=%0d data=%h", cyc, sample_data);
            end else begin
               $display("FAIL shift got data=%h cyc=%0d expected data=%h cyc=%0d",
                        sample_data, cyc, mon_e.data, mon_e.at);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act == expv) begin
         passes++;
         $display("check %s ok value=%0d", name, act);
      end else begin
         $display("FAIL %s got=%0d expected=%0d", name, act, expv);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_arm(output int t);
      arm = 1'b1;
      t = cyc;
      step(1);
      arm = 1'b0;
   endtask

   task automatic push_run(input int data, input int first, input int period, input int count);
      shift_exp_t e;
      for (int k = 0; k < count; k++) begin
         e.data = data;
         e.at   = first + k * period;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!capture_done && n < budget) begin
         step(1);
         n++;
      end
      check({name, "_done"}, int'(capture_done), 1);
      check({name, "_count"}, int'(sample_count), N);
      check({name, "_capturing"}, int'(capturing), 0);
      step(8);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_still_done"}, int'(capture_done), 1);
   endtask

   function automatic int outs_or();
      return int'(sample_shift) | int'(sample_data) | int'(armed) | int'(capturing) |
             int'(capture_done) | int'(sample_count);
   endfunction

   initial begin
      int t;
      int r;

      // Reset state
      step(3);
      check("in_reset_outputs", outs_or(), 0);
      reset = 1'b0;
      step(2);
      check("after_reset_outputs", outs_or(), 0);

      // Reset mid-capture (monitor off while the aborted capture runs)
      div_value = 0;
      trig_mask = '0;
      chan_in   = 10'h0F0;
      step(4);
      pulse_arm(t);
      goto_cyc(t + 10);
      check("midcap_capturing", int'(capturing), 1);
      check("midcap_count", int'(sample_count), 9);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", outs_or(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mon_en = 1'b1;
      step(20);
      check("post_reset_idle", int'(armed) | int'(capturing) | int'(capture_done), 0);

      // Free-running trigger, div_value=3: shifts every 4 clk
      div_value = 3;
      chan_in   = 10'h2A5;
      step(4);
      pulse_arm(t);
      check("armed_flag", int'(armed), 1);
      push_run(10'h2A5, t + 5, 4, N);
      wait_done("div3", 4 * N + 100);

      // Level trigger on ch0 high
      div_value  = 0;
      trig_mask  = 10'h001;
      trig_value = 10'h001;
      chan_in    = 10'h000;
      step(4);
      pulse_arm(t);
      step(12);
      check("level_still_armed", int'(armed), 1);
      r = cyc;
      chan_in = 10'h001;
      push_run(10'h001, r + 3, 1, N);
      wait_done("level", N + 100);

      // Edge trigger: ch0 already high at arm must not fire
      trig_edge = 1'b1;
      chan_in   = 10'h001;
      step(5);
      pulse_arm(t);
      step(12);
      check("edge_no_fire_high", int'(armed), 1);
      chan_in = 10'h000;
      step(6);
      check("edge_no_fire_low", int'(armed), 1);
      r = cyc;
      chan_in = 10'h001;
      push_run(10'h001, r + 3, 1, N);
      wait_done("edge", N + 100);

      // Channel enable masks ch0 out of the data
      trig_edge   = 1'b0;
      trig_mask   = '0;
      chan_in     = 10'h3FF;
      chan_enable = 10'h3FE;
      div_value   = 1;
      step(4);
      pulse_arm(t);
      push_run(10'h3FE, t + 3, 2, N);
      wait_done("enable", 2 * N + 100);

      // arm+abort together in DONE: abort wins
      arm   = 1'b1;
      abort = 1'b1;
      step(1);
      arm   = 1'b0;
      abort = 1'b0;
      check("abort_done_cleared", int'(capture_done), 0);
      check("abort_not_armed", int'(armed), 0);
      check("abort_count_cleared", int'(sample_count), 0);
      step(10);
      check("abort_stays_idle", int'(armed) | int'(capturing), 0);

      // Abort while ARMED on an unmet level trigger
      trig_mask  = 10'h001;
      trig_value = 10'h000;
      pulse_arm(t);
      step(5);
      check("armed_unmet", int'(armed), 1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("abort_from_armed", int'(armed), 0);

      // div_value lowered 100 -> 2 mid-period; arm during CAPTURE ignored
      trig_mask   = '0;
      chan_enable = '1;
      chan_in     = 10'h155;
      div_value   = 100;
      step(4);
      pulse_arm(t);
      push_run(10'h155, t + 102, 1, 1);
      push_run(10'h155, t + 153, 3, N - 1);
      goto_cyc(t + 152);
      div_value = 2;
      goto_cyc(t + 160);
      check("divlow_capturing", int'(capturing), 1);
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      check("arm_in_capture_ignored", int'(capturing), 1);
      wait_done("divlow", 3 * N + 100);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
